// File: rtl/cnn_layer_sequencer.sv
// Conv/pool stage sequencer: launches each enabled stage with a one-cycle pulse, waits for its
// done edge, and flags timeouts and done edges arriving from the wrong stage. All outputs registered.
module cnn_layer_sequencer #(
  parameter int                    NUM_LAYERS = 2,
  parameter logic [NUM_LAYERS-1:0] POOL_MASK  = {NUM_LAYERS{1'b1}},
  parameter int                    CNT_W      = 32,
  parameter int                    TIMEOUT    = 1000000,
  localparam int                   NS         = 2 * NUM_LAYERS,
  localparam int                   IW         = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NS-1:0]    stage_done,
  output logic [NS-1:0]    stage_start,
  output logic [IW-1:0]    cur_stage,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] stage_cycles,
  output logic             cycles_valid,
  output logic [CNT_W-1:0] total_cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_SPURIOUS = 2'b10;

  function automatic logic [NS-1:0] en_mask_f();
    logic [NS-1:0] m;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      m[2*l]   = 1'b1;
      m[2*l+1] = POOL_MASK[l];
    end
    return m;
  endfunction

  localparam logic [NS-1:0]    EN_MASK = en_mask_f();
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
  localparam bit               TMO_EN  = (TIMEOUT != 0);

  function automatic logic [NS-1:0] onehot(input logic [IW-1:0] i);
    return NS'(1) << i;
  endfunction

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NS-1:0]    sdone_prev_q;
  logic [NS-1:0]    stage_start_q, stage_start_d;
  logic [IW-1:0]    cur_stage_q, cur_stage_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] stage_cycles_q, stage_cycles_d;
  logic             cycles_valid_q, cycles_valid_d;
  logic [CNT_W-1:0] total_q, total_d;

  logic [NS-1:0]    done_edge;
  logic             spurious;
  logic             own_edge;
  logic [CNT_W-1:0] cnt_plus1;
  logic [CNT_W-1:0] total_plus1;
  logic             tmo_hit;
  logic [IW-1:0]    nxt_idx;
  logic             nxt_vld;

  always_comb begin
    done_edge   = stage_done & ~sdone_prev_q;
    // Skipped stages are not in onehot(idx_q), so their edges count as spurious too.
    spurious    = |(done_edge & ~onehot(idx_q));
    own_edge    = |(done_edge & onehot(idx_q));
    cnt_plus1   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    total_plus1 = (&total_q) ? total_q : total_q + CNT_W'(1);
    tmo_hit     = TMO_EN && (cnt_plus1 == TMO_VAL);

    nxt_idx = idx_q;
    nxt_vld = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (EN_MASK[i] && (i > int'(idx_q))) begin
        nxt_idx = IW'(i);
        nxt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    stage_start_d  = '0;
    cur_stage_d    = cur_stage_q;
    busy_d         = busy_q;
    done_d         = done_q;
    error_d        = error_q;
    err_code_d     = err_code_q;
    stage_cycles_d = stage_cycles_q;
    cycles_valid_d = 1'b0;
    total_d        = total_q;

    if (state_q == S_LAUNCH || state_q == S_WAIT) begin
      total_d = total_plus1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LAUNCH;
          idx_d         = '0;
          total_d       = '0;
          done_d        = 1'b0;
          busy_d        = 1'b1;
          stage_start_d = onehot('0);
          cur_stage_d   = '0;
        end
      end
      S_LAUNCH: begin
        cnt_d = '0;
        if (spurious) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = ERR_SPURIOUS;
          busy_d     = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_plus1;
        if (spurious) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = ERR_SPURIOUS;
          busy_d     = 1'b0;
        end else if (own_edge) begin
          stage_cycles_d = cnt_plus1;
          cycles_valid_d = 1'b1;
          if (nxt_vld) begin
            state_d       = S_LAUNCH;
            idx_d         = nxt_idx;
            stage_start_d = onehot(nxt_idx);
            cur_stage_d   = nxt_idx;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (tmo_hit) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          busy_d     = 1'b0;
        end
      end
      S_ERR: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything above, including a same-cycle start.
    if (abort) begin
      state_d        = S_IDLE;
      stage_start_d  = '0;
      cycles_valid_d = 1'b0;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      error_d        = 1'b0;
      err_code_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      sdone_prev_q   <= '0;
      stage_start_q  <= '0;
      cur_stage_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= '0;
      stage_cycles_q <= '0;
      cycles_valid_q <= 1'b0;
      total_q        <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      sdone_prev_q   <= stage_done;
      stage_start_q  <= stage_start_d;
      cur_stage_q    <= cur_stage_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      stage_cycles_q <= stage_cycles_d;
      cycles_valid_q <= cycles_valid_d;
      total_q        <= total_d;
    end
  end

  assign stage_start  = stage_start_q;
  assign cur_stage    = cur_stage_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign stage_cycles = stage_cycles_q;
  assign cycles_valid = cycles_valid_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench: instance a (all pools, TIMEOUT=16) runs a vector table plus corner sequences;
// instance b (POOL_MASK=01, no timeout) covers skipped stages.
module tb_cnn_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, a_abort = 1'b0;
  logic [3:0]  a_sdone = '0;
  logic [3:0]  a_stage_start;
  logic [1:0]  a_cur_stage;
  logic        a_busy, a_done, a_error, a_cycles_valid;
  logic [1:0]  a_err_code;
  logic [31:0] a_stage_cycles, a_total;

  logic        b_start = 1'b0, b_abort = 1'b0;
  logic [3:0]  b_sdone = '0;
  logic [3:0]  b_stage_start;
  logic [1:0]  b_cur_stage;
  logic        b_busy, b_done, b_error, b_cycles_valid;
  logic [1:0]  b_err_code;
  logic [31:0] b_stage_cycles, b_total;

  cnn_layer_sequencer #(.NUM_LAYERS(2), .POOL_MASK(2'b11), .CNT_W(32), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .stage_done(a_sdone),
    .stage_start(a_stage_start), .cur_stage(a_cur_stage), .busy(a_busy), .done(a_done),
    .error(a_error), .err_code(a_err_code), .stage_cycles(a_stage_cycles),
    .cycles_valid(a_cycles_valid), .total_cycles(a_total)
  );

  cnn_layer_sequencer #(.NUM_LAYERS(2), .POOL_MASK(2'b01), .CNT_W(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .stage_done(b_sdone),
    .stage_start(b_stage_start), .cur_stage(b_cur_stage), .busy(b_busy), .done(b_done),
    .error(b_error), .err_code(b_err_code), .stage_cycles(b_stage_cycles),
    .cycles_valid(b_cycles_valid), .total_cycles(b_total)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d[4];       // cycles from stage_start cycle to done edge, per stage
    bit hold;       // keep each done level high until the run ends
    int exp_total;  // sum of (d+1)
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_launch_a(input int s);
    for (int k = 0; k < 4 && a_stage_start == 4'd0; k++) tick();
    chk($sformatf("a_launch_stage%0d", s), 64'(a_stage_start), 64'(4'd1 << s));
    chk($sformatf("a_cur_stage%0d", s), 64'(a_cur_stage), 64'(s));
  endtask

  task automatic run_a(input vec_t v, input int n);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk($sformatf("v%0d_launch0_immediate", n), 64'(a_stage_start), 64'd1);
    chk($sformatf("v%0d_done_dropped", n), 64'(a_done), 64'd0);
    chk($sformatf("v%0d_total_restart", n), 64'(a_total), 64'd0);
    chk($sformatf("v%0d_busy", n), 64'(a_busy), 64'd1);
    for (int s = 0; s < 4; s++) begin
      wait_launch_a(s);
      repeat (v.d[s]) tick();
      a_sdone[s] = 1'b1;
      tick();
      chk($sformatf("v%0d_valid%0d", n, s), 64'(a_cycles_valid), 64'd1);
      chk($sformatf("v%0d_cycles%0d", n, s), 64'(a_stage_cycles), 64'(v.d[s]));
      if (!v.hold) a_sdone[s] = 1'b0;
    end
    chk($sformatf("v%0d_done", n), 64'(a_done), 64'd1);
    chk($sformatf("v%0d_busy_end", n), 64'(a_busy), 64'd0);
    chk($sformatf("v%0d_error", n), 64'(a_error), 64'd0);
    chk($sformatf("v%0d_total", n), 64'(a_total), 64'(v.exp_total));
    a_sdone = '0;
  endtask

  initial begin
    vecs[0] = '{'{4, 3, 2, 5}, 1'b0, 18};
    vecs[1] = '{'{1, 1, 1, 1}, 1'b1, 8};
    vecs[2] = '{'{16, 1, 1, 1}, 1'b1, 23};
    vecs[3] = '{'{7, 2, 9, 3}, 1'b0, 25};

    tick();
    chk("a_reset_outputs", 64'({a_stage_start, a_cur_stage, a_busy, a_done, a_error, a_err_code,
                                a_cycles_valid}), 64'd0);
    chk("a_reset_counts", {a_stage_cycles, a_total}, 64'd0);
    chk("b_reset_outputs", 64'({b_stage_start, b_busy, b_done, b_error, b_err_code}), 64'd0);
    rst = 1'b0;
    tick();

    // Back-to-back runs from the table; each start after the first arrives in DONE.
    for (int n = 0; n < 4; n++) run_a(vecs[n], n);

    // Timeout: stage 0 never completes.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("tmo_launch", 64'(a_stage_start), 64'd1);
    repeat (16) tick();
    chk("tmo_not_yet", 64'({a_error, a_busy}), 64'b01);
    tick();
    chk("tmo_error", 64'(a_error), 64'd1);
    chk("tmo_code", 64'(a_err_code), 64'b01);
    chk("tmo_busy", 64'(a_busy), 64'd0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    chk("err_start_ignored", 64'({a_stage_start, a_busy}), 64'd0);
    chk("err_held", 64'(a_error), 64'd1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort_clears_err", 64'({a_error, a_err_code, a_done, a_busy}), 64'd0);

    // Own-stage edge and spurious edge in the same cycle.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (2) tick();
    a_sdone[0] = 1'b1;
    tick();
    wait_launch_a(1);
    tick();
    a_sdone[1] = 1'b1;
    a_sdone[3] = 1'b1;
    tick();
    chk("spur_error", 64'(a_error), 64'd1);
    chk("spur_code", 64'(a_err_code), 64'b10);
    chk("spur_no_valid", 64'(a_cycles_valid), 64'd0);
    a_abort = 1'b1;
    a_sdone = '0;
    tick();
    a_abort = 1'b0;
    chk("abort_after_spur", 64'(a_error), 64'd0);

    // Abort and start together in WAIT.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("ab_launch", 64'(a_stage_start), 64'd1);
    repeat (3) tick();
    a_start = 1'b1;
    a_abort = 1'b1;
    tick();
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("ab_idle", 64'({a_busy, a_done, a_stage_start}), 64'd0);
    chk("ab_total_kept", 64'(a_total), 64'd4);
    tick();
    chk("ab_no_launch", 64'({a_busy, a_stage_start}), 64'd0);

    // Reset in the middle of WAIT.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_a_outputs", 64'({a_stage_start, a_cur_stage, a_busy, a_done, a_error, a_err_code,
                              a_cycles_valid}), 64'd0);
    chk("rst_a_counts", {a_stage_cycles, a_total}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_no_launch", 64'({a_stage_start, a_busy}), 64'd0);

    // Instance b: stage 3 skipped.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4 && b_stage_start == 4'd0; k++) tick();
      chk($sformatf("b_launch%0d", s), 64'(b_stage_start), 64'(4'd1 << s));
      repeat (3) tick();
      b_sdone[s] = 1'b1;
      tick();
      chk($sformatf("b_cycles%0d", s), 64'(b_stage_cycles), 64'd3);
    end
    chk("b_done_after_2", 64'({b_done, b_busy, b_stage_start}), 64'b10_0000);
    chk("b_total", 64'(b_total), 64'd12);
    tick();
    chk("b_stage3_never", 64'(b_stage_start), 64'd0);
    b_sdone = '0;
    tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (2) tick();
    b_sdone[0] = 1'b1;
    tick();
    chk("b2_launch1", 64'(b_stage_start), 64'b0010);
    tick();
    b_sdone[3] = 1'b1;
    tick();
    chk("b_skipped_spur", 64'({b_error, b_err_code}), 64'b110);
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
